matrix_mul2x2: RTL
==================

MATRIX_MUL2X2 -- requirements
Module: matrix_mul2x2

Interface
REQ-001 Parameter TOL, default 16, sets the identity-check tolerance in Q2.14 LSBs.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to capture operands; sampled only when busy=0.
REQ-005 a, b, c, d  input  16 signed each  matrix M = [a b; c d], Q2.14.
REQ-006 e, f, g, h  input  16 signed each  matrix N = [e f; g h], Q2.14, typically the inverse of M.
REQ-007 p00, p01, p10, p11  output  16 signed each  product P = M*N, Q2.14, registered.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse when P, is_identity and overflow are updated.
REQ-010 is_identity  output  1  P is within TOL of the Q2.14 identity matrix.
REQ-011 overflow  output  1  at least one entry of the last result saturated.

Function
REQ-012 The FSM SHALL have states IDLE, CALC, CHECK and DONE, with transitions as follows.
- IDLE->CALC on start=1; CALC holds for 4 cycles; then CHECK; then DONE; then IDLE.
REQ-013 At the start-sampling edge k, the block SHALL latch all eight operands into internal registers and SHALL clear the internal overflow accumulator.
REQ-014 One entry per cycle SHALL be computed in CALC, in the order p00, p01, p10, p11, at edges k+1 to k+4.
- p00 = a*e + b*g
- p01 = a*f + b*h
- p10 = c*e + d*g
- p11 = c*f + d*h
REQ-015 The arithmetic SHALL be as follows.
- Each product is full 32-bit signed (Q4.28).
- The sum is 33-bit.
- Add 2^13 (round half up), then arithmetic shift right by 14.
- Saturate to [-32768, 32767]; any saturation sets the overflow accumulator.
REQ-016 In CHECK (edge k+5), the block SHALL evaluate is_identity using absolute differences in at least 17-bit arithmetic.
- |p00-16384| <= TOL, |p11-16384| <= TOL, |p01| <= TOL, |p10| <= TOL.
REQ-017 The output registers p00..p11, is_identity and overflow SHALL update only at edge k+5; otherwise they hold their previous values.
REQ-018 done SHALL be 1 for exactly the one cycle following edge k+5 and 0 at all other times.
REQ-019 busy SHALL be 1 from edge k until edge k+5, and SHALL be 0 while done=1.
REQ-020 Fixed latency: done is high 6 cycles after the start-sampling edge.
REQ-021 start asserted while busy=1 SHALL be ignored, and the latched operands SHALL be unaffected by input changes during an operation.
REQ-022 start=1 in the same cycle that done=1 SHALL be accepted; that edge both leaves DONE and captures new operands (back-to-back throughput of one result per 6 cycles).
REQ-023 A held-high start SHALL launch a new operation every 6 cycles; no edge detection is performed.

Reset
REQ-024 While reset=1, the block SHALL immediately force the following, independent of clk.
- State IDLE.
- p00..p11 = 0, busy = 0, done = 0, is_identity = 0, overflow = 0.
- All operand and accumulator registers cleared.
REQ-025 Reset asserted mid-operation SHALL abort the operation, with no done pulse and no output update.
REQ-026 The first start SHALL be accepted at the first rising edge after reset deasserts.

Structure
REQ-027 A shared package matrix_pkg SHALL hold the following.
- Q-format constants: WIDTH=16, FRAC=14, ONE=16384, ROUND=8192, SAT_MAX, SAT_MIN.
- The FSM state encoding.
REQ-028 One sub-module, q_dot2, SHALL be used: a combinational two-term dot product with round and saturate, with a sat flag output, instantiated once and time-shared across the four CALC cycles.

Verification
REQ-029 Identity test: M = N = [16384 0; 0 16384], start -> after 6 cycles P = [16384 0; 0 16384], is_identity=1, overflow=0, done exactly 1 cycle.
REQ-030 Scaling test: M = [8192 0; 0 8192], N = [16384 0; 0 16384] -> P = [8192 0; 0 8192], is_identity=0, overflow=0.
REQ-031 Sign test: M = N = [-16384 0; 0 -16384] -> P = [16384 0; 0 16384], is_identity=1.
REQ-032 Rounding/saturation test, in two steps.
- a=1, e=8192, all other operands 0 -> p00=1 (half rounds up).
- All operands 32767 -> all entries 32767, overflow=1.
REQ-033 Handshake test, in three parts.
- start pulsed at busy cycle 2 with different operands -> ignored, result unchanged.
- start held high -> done every 6 cycles.
- start in the done cycle -> accepted.
REQ-034 Reset test: reset asserted at CALC cycle 3 -> all outputs 0 immediately, no done pulse; the next start gives a correct result 6 cycles later.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared Q2.14 constants, FSM encoding and a distance helper for the 2x2 matrix multiplier.
// Latency: not applicable (declarations only).
// Backpressure: not applicable.
package matrix_pkg;

    localparam int WIDTH = 16;
    localparam int FRAC  = 14;
    localparam int ONE   = 16384;
    localparam int ROUND = 8192;

    localparam logic signed [WIDTH-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [WIDTH-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // |v - target| in 18-bit arithmetic so the difference of two 16-bit values never wraps
    function automatic logic [17:0] abs_dist(input logic signed [WIDTH-1:0] v,
                                             input logic signed [WIDTH-1:0] target);
        logic signed [17:0] diff;
        diff = 18'(v) - 18'(target);
        if (diff < 0)
            return $unsigned(-diff);
        else
            return $unsigned(diff);
    endfunction

endpackage

// File: rtl/matrix_mul2x2_q_dot2.sv
// Combinational two-term Q2.14 dot product x0*y0 + x1*y1 with round-half-up and saturation.
// Latency: zero cycles (purely combinational).
// Backpressure: none; output follows inputs.
module q_dot2
    import matrix_pkg::*;
(
    input  logic signed [WIDTH-1:0] x0,
    input  logic signed [WIDTH-1:0] y0,
    input  logic signed [WIDTH-1:0] x1,
    input  logic signed [WIDTH-1:0] y1,
    output logic signed [WIDTH-1:0] r,
    output logic                    sat
);

    logic signed [31:0] m0;
    logic signed [31:0] m1;
    logic signed [32:0] s;
    logic signed [33-FRAC:0] sh;

    // Q4.28 products, 33-bit sum, +2^13 then shift back to Q2.14, then clamp to 16 bits
    always_comb begin
        m0  = 32'(x0) * 32'(y0);
        m1  = 32'(x1) * 32'(y1);
        s   = {m0[31], m0} + {m1[31], m1};
        sh  = (34-FRAC)'(({s[32], s} + 34'(ROUND)) >>> FRAC);
        r   = sh[WIDTH-1:0];
        sat = 1'b0;
        if (sh > (34-FRAC)'(SAT_MAX)) begin
            r   = SAT_MAX;
            sat = 1'b1;
        end else if (sh < (34-FRAC)'(SAT_MIN)) begin
            r   = SAT_MIN;
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/matrix_mul2x2.sv
// 2x2 Q2.14 matrix product P = M*N with identity check, one shared dot-product unit.
// Latency: done pulses in the cycle after the 5th edge following the start-sampling edge.
// Backpressure: start is ignored while busy; start in the done cycle is accepted.
module matrix_mul2x2
    import matrix_pkg::*;
#(
    parameter int TOL = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic signed [WIDTH-1:0] c,
    input  logic signed [WIDTH-1:0] d,
    input  logic signed [WIDTH-1:0] e,
    input  logic signed [WIDTH-1:0] f,
    input  logic signed [WIDTH-1:0] g,
    input  logic signed [WIDTH-1:0] h,
    output logic signed [WIDTH-1:0] p00,
    output logic signed [WIDTH-1:0] p01,
    output logic signed [WIDTH-1:0] p10,
    output logic signed [WIDTH-1:0] p11,
    output logic                    busy,
    output logic                    done,
    output logic                    is_identity,
    output logic                    overflow
);

    localparam logic [17:0] TOL_L = 18'(TOL);
    localparam logic signed [WIDTH-1:0] ONE_Q = WIDTH'(ONE);

    state_t state;
    logic [1:0] idx;

    // operand latches so inputs may change freely during an operation
    logic signed [WIDTH-1:0] ra, rb, rc, rd, re, rf, rg, rh;
    // intermediate results, published together at the CHECK edge
    logic signed [WIDTH-1:0] t00, t01, t10, t11;
    logic                    ovf_acc;

    logic signed [WIDTH-1:0] x0, y0, x1, y1;
    logic signed [WIDTH-1:0] dot_r;
    logic                    dot_sat;
    logic                    id_ok;

    // select the row/column pair for the entry being computed this CALC cycle
    always_comb begin
        x0 = ra;
        x1 = rb;
        y0 = re;
        y1 = rg;
        case (idx)
            2'd0: begin x0 = ra; x1 = rb; y0 = re; y1 = rg; end
            2'd1: begin x0 = ra; x1 = rb; y0 = rf; y1 = rh; end
            2'd2: begin x0 = rc; x1 = rd; y0 = re; y1 = rg; end
            default: begin x0 = rc; x1 = rd; y0 = rf; y1 = rh; end
        endcase
    end

    q_dot2 u_dot (
        .x0  (x0),
        .y0  (y0),
        .x1  (x1),
        .y1  (y1),
        .r   (dot_r),
        .sat (dot_sat)
    );

    // identity test on the freshly computed entries, evaluated in CHECK
    always_comb begin
        id_ok = (abs_dist(t00, ONE_Q) <= TOL_L) &&
                (abs_dist(t11, ONE_Q) <= TOL_L) &&
                (abs_dist(t01, '0)    <= TOL_L) &&
                (abs_dist(t10, '0)    <= TOL_L);
    end

    // control FSM with operand capture, per-entry accumulation and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            ra <= '0; rb <= '0; rc <= '0; rd <= '0;
            re <= '0; rf <= '0; rg <= '0; rh <= '0;
            t00 <= '0; t01 <= '0; t10 <= '0; t11 <= '0;
            ovf_acc     <= 1'b0;
            p00 <= '0; p01 <= '0; p10 <= '0; p11 <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            is_identity <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        ra <= a; rb <= b; rc <= c; rd <= d;
                        re <= e; rf <= f; rg <= g; rh <= h;
                        ovf_acc <= 1'b0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= S_CALC;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    case (idx)
                        2'd0:    t00 <= dot_r;
                        2'd1:    t01 <= dot_r;
                        2'd2:    t10 <= dot_r;
                        default: t11 <= dot_r;
                    endcase
                    ovf_acc <= ovf_acc | dot_sat;
                    idx     <= idx + 2'd1;
                    if (idx == 2'd3)
                        state <= S_CHECK;
                end
                default: begin
                    p00         <= t00;
                    p01         <= t01;
                    p10         <= t10;
                    p11         <= t11;
                    is_identity <= id_ok;
                    overflow    <= ovf_acc;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_DONE;
                end
            endcase
        end
    end

endmodule
